mfcc_melbank_reader: RTL and testbench

//  Consumer side of the mel filterbank coefficient ROM (512x8, combinational read).

---
 rtl/mfcc_melbank_reader.sv | 137 +++++++++++++
 tb/tb_mfcc_melbank_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_melbank_reader.sv
// Mel filterbank reader: per power bin, fetch band index and weight from the coefficient ROM,
// accumulate into two overlapping triangular bands, then stream all band energies at frame end.
module mfcc_melbank_reader #(
  parameter int NBINS   = 256,
  parameter int NBANDS  = 26,
  parameter int PWR_W   = 32,
  parameter int ACC_W   = 48,
  parameter int ROM_LAT = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [PWR_W-1:0] i_s_data,
  input  logic             i_s_last,
  output logic [8:0]       o_rom_addr,
  input  logic [7:0]       i_rom_rd_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [ACC_W-1:0] o_m_data,
  output logic [7:0]       o_m_band,
  output logic             o_m_last,
  output logic             o_frame_err
);

  localparam int LW  = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
  localparam int BIW = (NBANDS > 1) ? $clog2(NBANDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_IDX, S_WGT, S_MAC, S_DUMP} state_t;

  state_t             r_state, w_next;
  logic [LW-1:0]      r_lat;
  logic [7:0]         r_k, r_lo, r_w, r_band;
  logic [PWR_W-1:0]   r_pwr;
  logic [ACC_W-1:0]   r_acc [NBANDS];
  logic [8:0]         r_rom_addr;
  logic               r_frame_err;
  logic               w_lat_done, w_cap, w_m_hs, w_last_bin, w_last_band;
  logic [PWR_W+7:0]   w_prod_lo, w_prod_hi;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PWR_W+7:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign w_lat_done  = (r_lat == LW'(ROM_LAT));
  assign w_cap       = i_s_valid & o_s_ready;
  assign w_m_hs      = o_m_valid & i_m_ready;
  assign w_last_bin  = (r_k == 8'(NBINS - 1));
  assign w_last_band = (r_band == 8'(NBANDS - 1));
  assign w_prod_lo   = r_pwr * r_w;
  assign w_prod_hi   = r_pwr * (8'd255 - r_w);
  assign o_rom_addr  = r_rom_addr;
  assign o_frame_err = r_frame_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_s_ready = 1'b0;
    o_m_valid = 1'b0;
    o_m_data  = '0;
    o_m_band  = 8'd0;
    o_m_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_s_ready = ~i_rst;
        if (w_cap) w_next = S_IDX;
      end
      S_IDX:  if (w_lat_done) w_next = S_WGT;
      S_WGT:  if (w_lat_done) w_next = S_MAC;
      S_MAC:  w_next = w_last_bin ? S_DUMP : S_IDLE;
      S_DUMP: begin
        o_m_valid = 1'b1;
        o_m_data  = r_acc[r_band[BIW-1:0]];
        o_m_band  = r_band;
        o_m_last  = w_last_band;
        if (w_m_hs && w_last_band) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lat       <= '0;
      r_k         <= 8'd0;
      r_lo        <= 8'd0;
      r_w         <= 8'd0;
      r_band      <= 8'd0;
      r_pwr       <= '0;
      r_rom_addr  <= 9'd0;
      r_frame_err <= 1'b0;
      for (int b = 0; b < NBANDS; b++) r_acc[b] <= '0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_cap) begin
          r_pwr       <= i_s_data;
          r_frame_err <= (i_s_last != w_last_bin);
          r_rom_addr  <= {1'b1, r_k};
          r_lat       <= '0;
        end
        S_IDX: if (w_lat_done) begin
          r_lo       <= i_rom_rd_data;
          r_rom_addr <= {1'b0, r_k};
          r_lat      <= '0;
        end else begin
          r_lat <= r_lat + LW'(1);
        end
        S_WGT: if (w_lat_done) r_w <= i_rom_rd_data;
               else            r_lat <= r_lat + LW'(1);
        S_MAC: begin
          // lo = 8'hFF never matches a band; the upper term is dropped past the last band
          for (int b = 0; b < NBANDS; b++) begin
            if (r_lo == 8'(b))
              r_acc[b] <= sat_add(r_acc[b], w_prod_lo);
            else if (({1'b0, r_lo} + 9'd1) == 9'(b))
              r_acc[b] <= sat_add(r_acc[b], w_prod_hi);
          end
          r_k <= w_last_bin ? 8'd0 : r_k + 8'd1;
        end
        S_DUMP: if (w_m_hs) begin
          r_acc[r_band[BIW-1:0]] <= '0;
          r_band <= w_last_band ? 8'd0 : r_band + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc_melbank_reader.sv
// Bench for mfcc_melbank_reader: three instances (ROM_LAT 0, ROM_LAT 1, ACC_W 40) with ROM models,
// a queue of expected band outputs and a monitor that checks every band handshake.
module tb_mfcc_melbank_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [3];
  logic        s_valid  [3];
  logic        s_ready  [3];
  logic [31:0] s_data   [3];
  logic        s_last   [3];
  logic [8:0]  rom_addr [3];
  logic        m_valid  [3];
  logic        m_ready  [3];
  logic [47:0] m_data   [3];
  logic [7:0]  m_band   [3];
  logic        m_last   [3];
  logic        frame_err[3];

  logic [7:0]  rlo [3][256];
  logic [7:0]  rw  [3][256];

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int LAT = (i == 1) ? 1 : 0;
    localparam int AW  = (i == 2) ? 40 : 48;
    logic [7:0]    rd, rom_q;
    logic [AW-1:0] md;
    assign rom_q = rom_addr[i][8] ? rlo[i][rom_addr[i][7:0]] : rw[i][rom_addr[i][7:0]];
    if (LAT == 0) begin : g_l0
      assign rd = rom_q;
    end else begin : g_l1
      always @(posedge clk) rd <= rom_q;
    end
    assign m_data[i] = 48'(md);
    mfcc_melbank_reader #(.ROM_LAT(LAT), .ACC_W(AW)) u_dut (
      .i_clk(clk), .i_rst(rst[i]),
      .i_s_valid(s_valid[i]), .o_s_ready(s_ready[i]), .i_s_data(s_data[i]), .i_s_last(s_last[i]),
      .o_rom_addr(rom_addr[i]), .i_rom_rd_data(rd),
      .o_m_valid(m_valid[i]), .i_m_ready(m_ready[i]), .o_m_data(md),
      .o_m_band(m_band[i]), .o_m_last(m_last[i]), .o_frame_err(frame_err[i])
    );
  end

  typedef struct {
    int          dut;
    logic [7:0]  band;
    logic [47:0] data;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          fe_cnt [3] = '{0, 0, 0};
  bit          stalled[3] = '{0, 0, 0};
  logic [47:0] hold_d [3];
  logic [7:0]  hold_b [3];
  bit          tog    [3] = '{0, 0, 0};
  logic [31:0] pw [256];
  logic [47:0] ex [26];

  // Monitor: frame_err pulse counting, hold-while-stalled check, scoreboard pop on handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (frame_err[d] === 1'b1) fe_cnt[d]++;
      if (stalled[d]) begin
        total++;
        if (!(m_valid[d] === 1'b1 && m_data[d] === hold_d[d] && m_band[d] === hold_b[d])) begin
          bad++;
          $display("FAIL stall_hold dut%0d: got valid=%b band=%0d data=%0h, held band=%0d data=%0h",
                   d, m_valid[d], m_band[d], m_data[d], hold_b[d], hold_d[d]);
        end
      end
      stalled[d] = (m_valid[d] === 1'b1) && (m_ready[d] === 1'b0);
      hold_d[d]  = m_data[d];
      hold_b[d]  = m_band[d];
      if (m_valid[d] === 1'b1 && m_ready[d] === 1'b1) begin
        total++;
        if (q.size() == 0 || q[0].dut != d) begin
          bad++;
          $display("FAIL unexpected_band dut%0d: got band=%0d data=%0h, no output expected",
                   d, m_band[d], m_data[d]);
        end else begin
          e = q.pop_front();
          if (m_band[d] !== e.band || m_data[d] !== e.data || m_last[d] !== e.last) begin
            bad++;
            $display("FAIL band_out dut%0d: got band=%0d data=%0d last=%b, expected band=%0d data=%0d last=%b",
                     d, m_band[d], m_data[d], m_last[d], e.band, e.data, e.last);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) if (tog[d]) m_ready[d] = ~m_ready[d];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bin(input int d, input logic [31:0] p, input bit last);
    int t = 0;
    @(negedge clk);
    while (s_ready[d] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (s_ready[d] !== 1'b1) begin
      chk($sformatf("s_ready_timeout dut%0d", d), 64'(s_ready[d]), 64'd1);
    end else begin
      s_valid[d] = 1'b1;
      s_data[d]  = p;
      s_last[d]  = last;
      @(posedge clk);
      #1;
      s_valid[d] = 1'b0;
      s_last[d]  = 1'b0;
      s_data[d]  = 32'd0;
    end
  endtask

  task automatic run_bins(input int d, input int upto, input int early);
    for (int k = 0; k <= upto; k++) send_bin(d, pw[k], (k == 255) || (k == early));
  endtask

  task automatic push_frame(input int d);
    for (int b = 0; b < 26; b++) q.push_back('{d, 8'(b), ex[b], (b == 25)});
  endtask

  task automatic wait_drain(input int d);
    int t = 0;
    while (q.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("drain_left dut%0d", d), 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset(input int d);
    chk($sformatf("rst_s_ready dut%0d", d),   64'(s_ready[d]),   64'd0);
    chk($sformatf("rst_rom_addr dut%0d", d),  64'(rom_addr[d]),  64'd0);
    chk($sformatf("rst_m_valid dut%0d", d),   64'(m_valid[d]),   64'd0);
    chk($sformatf("rst_m_data dut%0d", d),    64'(m_data[d]),    64'd0);
    chk($sformatf("rst_m_band dut%0d", d),    64'(m_band[d]),    64'd0);
    chk($sformatf("rst_m_last dut%0d", d),    64'(m_last[d]),    64'd0);
    chk($sformatf("rst_frame_err dut%0d", d), 64'(frame_err[d]), 64'd0);
  endtask

  task automatic clear_pw_ex();
    for (int k = 0; k < 256; k++) pw[k] = 32'd0;
    for (int b = 0; b < 26; b++) ex[b] = 48'd0;
  endtask

  // Single isolated bin: 1000*200 into band 3, 1000*55 into band 4.
  task automatic frame_basic(input int d);
    int fe0;
    clear_pw_ex();
    pw[10] = 32'd1000;
    ex[3]  = 48'd200000;
    ex[4]  = 48'd55000;
    fe0 = fe_cnt[d];
    push_frame(d);
    run_bins(d, 255, -1);
    wait_drain(d);
    chk($sformatf("frame_err_none dut%0d", d), 64'(fe_cnt[d] - fe0), 64'd0);
  endtask

  // Partial frame with different powers, reset during MAC of bin 50, then a clean frame.
  task automatic reset_in_mac(input int d, input int lat);
    clear_pw_ex();
    pw[10] = 32'd777;
    pw[20] = 32'd9;
    pw[30] = 32'd3;
    run_bins(d, 50, -1);
    repeat (2 + 2 * lat) @(posedge clk);
    #1 rst[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset(d);
    rst[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("post_rst_s_ready dut%0d", d), 64'(s_ready[d]), 64'd1);
    frame_basic(d);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; s_valid[d] = 1'b0; s_data[d] = 32'd0; s_last[d] = 1'b0; m_ready[d] = 1'b1;
      for (int k = 0; k < 256; k++) begin
        rlo[d][k] = (d == 2) ? 8'd0 : 8'hFF;
        rw[d][k]  = (d == 2) ? 8'd255 : 8'd0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      rlo[d][10] = 8'd3;  rw[d][10] = 8'd200;
      rlo[d][20] = 8'd25; rw[d][20] = 8'd100;
      rlo[d][30] = 8'd7;  rw[d][30] = 8'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset(d);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    frame_basic(0);

    // Last band clipping, zero weight, out-of-band bin, early s_last, stalled output.
    begin
      int fe0;
      clear_pw_ex();
      pw[10] = 32'd1000;
      pw[20] = 32'd4;
      pw[30] = 32'd5;
      pw[40] = 32'd12345;
      ex[3]  = 48'd200000;
      ex[4]  = 48'd55000;
      ex[8]  = 48'd1275;
      ex[25] = 48'd400;
      fe0 = fe_cnt[0];
      tog[0] = 1'b1;
      push_frame(0);
      run_bins(0, 255, 100);
      wait_drain(0);
      tog[0] = 1'b0;
      @(posedge clk);
      #2 m_ready[0] = 1'b1;
      chk("frame_err_once dut0", 64'(fe_cnt[0] - fe0), 64'd1);
    end

    frame_basic(0);
    reset_in_mac(0, 0);

    frame_basic(1);
    reset_in_mac(1, 1);

    // Saturation: every bin adds ~2^40 into band 0 of the 40-bit instance.
    clear_pw_ex();
    for (int k = 0; k < 256; k++) pw[k] = 32'hFFFF_FFFF;
    ex[0] = 48'h00FF_FFFF_FFFF;
    push_frame(2);
    run_bins(2, 255, -1);
    wait_drain(2);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
